// File: rtl/isr_control.sv
// isr_control: in-service register, priority resolution and the two-pulse INTA handshake.
// Define ROTATE_PRIORITY_EN to enable rotating priority; the default build uses fixed IR0-highest priority.
module isr_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta,
  input  logic       eoi,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       aeoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] isr,
  output logic       reset_irr_bit,
  output logic [7:0] data_out,
  output logic       data_en
);

  typedef enum logic [1:0] {IDLE, REQ, ACK1} state_t;

  state_t     state, state_nx;
  logic       inta_q, inta_edge;
  logic       spurious, spurious_nx;
  logic       rirr_nx, den_nx;
  logic [2:0] level, level_nx, ptr;
  logic [7:0] cand, isr_set, isr_clr, isr_nx, dout_nx;
  logic [3:0] cand_top, isr_top;
  logic       win;
`ifdef ROTATE_PRIORITY_EN
  logic [2:0] ptr_nx;
`endif

  // Highest-priority set bit of v: {found, level}. Priority descends from p+1 (mod 8).
  function automatic logic [3:0] top_of(input logic [7:0] v, input logic [2:0] p);
    logic [3:0] r;
    logic [2:0] l;
    r = '0;
    for (int unsigned k = 8; k > 0; k--) begin
      l = p + 3'(k);
      if (v[l]) r = {1'b1, l};
    end
    return r;
  endfunction

  assign inta_edge = inta & ~inta_q;
  assign cand      = irr & ~imr;
  assign cand_top  = top_of(cand, ptr);
  assign isr_top   = top_of(isr, ptr);
  // Rank relative to the pointer: smaller rank means higher priority.
  assign win = cand_top[3] &
               (~isr_top[3] | (3'(cand_top[2:0] - ptr - 3'd1) < 3'(isr_top[2:0] - ptr - 3'd1)));
  assign int_out = (state == REQ);

  always_comb begin
    state_nx    = state;
    level_nx    = level;
    spurious_nx = spurious;
    rirr_nx     = 1'b0;
    dout_nx     = data_out;
    den_nx      = data_en;
    isr_set     = '0;
    isr_clr     = '0;
`ifdef ROTATE_PRIORITY_EN
    ptr_nx      = ptr;
`endif
    if (eoi) begin
      if (eoi_specific) begin
        isr_clr[eoi_level] = 1'b1;
      end else if (isr_top[3]) begin
        isr_clr[isr_top[2:0]] = 1'b1;
`ifdef ROTATE_PRIORITY_EN
        ptr_nx = isr_top[2:0];
`endif
      end
    end
    case (state)
      IDLE: if (win) state_nx = REQ;
      REQ: begin
        if (inta_edge) begin
          level_nx    = win ? cand_top[2:0] : 3'd7;
          spurious_nx = ~win;
          if (win) isr_set[cand_top[2:0]] = 1'b1;
          rirr_nx  = 1'b1;
          state_nx = ACK1;
        end
      end
      ACK1: begin
        // data_en doubles as the "second acknowledge seen" marker.
        if (inta_edge && !data_en) begin
          dout_nx = {vector_base, level};
          den_nx  = 1'b1;
          if (aeoi && !spurious) begin
            isr_clr[level] = 1'b1;
`ifdef ROTATE_PRIORITY_EN
            ptr_nx = level;
`endif
          end
        end else if (data_en && !inta) begin
          den_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Clears come from the pre-update isr; a set on the same bit wins.
    isr_nx = (isr & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      inta_q        <= 1'b0;
      level         <= '0;
      spurious      <= 1'b0;
      isr           <= '0;
      reset_irr_bit <= 1'b0;
      data_out      <= '0;
      data_en       <= 1'b0;
    end else begin
      state         <= state_nx;
      inta_q        <= inta;
      level         <= level_nx;
      spurious      <= spurious_nx;
      isr           <= isr_nx;
      reset_irr_bit <= rirr_nx;
      data_out      <= dout_nx;
      data_en       <= den_nx;
    end
  end

`ifdef ROTATE_PRIORITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= 3'd7;
    else       ptr <= ptr_nx;
  end
`else
  assign ptr = 3'd7;
`endif

endmodule

// File: doc/isr_control.md
ISR_CONTROL -- requirements
Module: isr_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL change only on the rising edge of clk or on assertion of reset.
REQ-002 Ports SHALL be:
- clk  input  1  system clock
- reset  input  1  async active-high reset
- irr  input  8  latched requests from the request register
- imr  input  8  mask; 1 = level masked
- inta  input  1  CPU acknowledge strobe, active-high, synchronous to clk
- eoi  input  1  one-cycle end-of-interrupt command strobe
- eoi_specific  input  1  1 = specific EOI using eoi_level; 0 = non-specific
- eoi_level  input  3  level for specific EOI
- aeoi  input  1  1 = automatic EOI on the second acknowledge
- vector_base  input  5  vector bits 7:3
- int_out  output  1  interrupt request to CPU
- isr  output  8  in-service register
- reset_irr_bit  output  1  one-cycle pulse telling the request register to clear serviced bits
- data_out  output  8  interrupt vector
- data_en  output  1  data_out valid / bus drive enable

Function
REQ-003 An inta edge SHALL be inta high in the current cycle and low in the previous cycle; inta_q SHALL be a registered copy of inta.
REQ-004 Candidates SHALL be irr & ~imr; the winner SHALL be the highest-priority candidate strictly higher in priority than the highest-priority set isr bit.
- Equal or lower levels SHALL not win.
REQ-005 The state machine SHALL have three states: IDLE, REQ, ACK1.
REQ-006 In IDLE, if a winner exists, the block SHALL move to REQ, with int_out high from the next cycle.
REQ-007 In REQ, int_out SHALL stay high.
- On an inta edge, level SHALL latch the winner of that cycle and isr[level] SHALL be set.
- reset_irr_bit SHALL pulse high for exactly the following cycle, by which time isr is already updated.
- int_out SHALL go low and the state SHALL become ACK1.
REQ-008 If no winner exists at the first inta edge (request withdrawn), level SHALL be 7, no isr bit SHALL be set, and reset_irr_bit SHALL still pulse (spurious acknowledge).
REQ-009 In ACK1, on the second inta edge:
- data_out SHALL equal {vector_base, level} and data_en SHALL be high from the next cycle while inta stays high.
- If aeoi = 1 and the acknowledge was not spurious, isr[level] SHALL clear in that same cycle.
REQ-010 When inta falls in ACK1 after the second edge, data_en SHALL drop in the next cycle and the state SHALL become IDLE; data_out SHALL hold its last value.
REQ-011 A non-specific eoi SHALL clear the highest-priority set isr bit; a specific eoi SHALL clear isr[eoi_level]; eoi on an empty isr SHALL have no effect.
- eoi SHALL act in every state.
REQ-012 Simultaneous eoi and isr set in the same cycle:
- Clears SHALL be computed from the pre-update isr.
- Set SHALL be applied after clears, so a set on the same bit wins.
REQ-013 A winner appearing in REQ at a higher level than the one pending SHALL be the one acknowledged; no extra int_out pulse SHALL occur.

Reset
REQ-014 On reset the outputs SHALL be:
- int_out 0, isr 8'h00, reset_irr_bit 0, data_out 8'h00, data_en 0.
- State IDLE, inta_q 0, level 0, priority pointer 7.
REQ-015 Reset mid-handshake SHALL abort the sequence; the next inta edge after release SHALL be treated as a first acknowledge only if the block has reached REQ.

Configuration
REQ-016 With ROTATE_PRIORITY_EN defined:
- A 3-bit pointer SHALL hold the lowest-priority level, and priority SHALL descend from pointer+1 modulo 8.
- Each non-specific eoi, and each AEOI clear, SHALL load the pointer with the cleared level.
- Specific eoi SHALL not move the pointer.
REQ-017 Without ROTATE_PRIORITY_EN, priority SHALL be fixed (IR0 highest, IR7 lowest), and the pointer SHALL be absent.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- irr=8'h24, imr=0, vector_base=5'h10, aeoi=0, two inta pulses -> int_out high, isr=8'h04, one reset_irr_bit pulse, data_out=8'h82, data_en high during second inta.
- isr=8'h04 in service, irr=8'h08 -> no int_out; irr=8'h01 -> int_out, nested ack gives isr=8'h05; non-specific eoi -> isr=8'h04.
- irr goes to 0 between int_out and first inta -> isr unchanged, reset_irr_bit pulses, data_out={vector_base,3'd7}.
- aeoi=1, irr=8'h80 -> isr=8'h80 after first inta, 8'h00 after second inta.
- ROTATE_PRIORITY_EN, service IR2 then non-specific eoi, then irr=8'h09 -> IR3 acknowledged first (vector level 3).
- reset asserted while in ACK1 -> all outputs at reset values immediately; fresh irr=8'h01 completes a normal two-inta sequence afterwards.
